// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transaction engine: FSM states, the 48-bit
// command-address word and the latched transfer descriptor.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        WRITE,
        READ,
        HOLD,
        RWR
    } state_e;

    typedef struct packed {
        logic        rw;
        logic        as;
        logic        burst;
        logic [28:0] addr_hi;
        logic [12:0] rsvd;
        logic [2:0]  addr_lo;
    } ca_t;

    // Burst length and chip select are parameter-sized and are kept beside this struct.
    typedef struct packed {
        logic        write;
        logic        reg_space;
        logic        linear;
        logic [31:0] addr;
    } trans_t;

    localparam int CaCycles = 3;

endpackage

// File: rtl/hyperbus_ca_pack.sv
// Builds the 48-bit command-address word from a latched descriptor.
module hyperbus_ca_pack
    import hyperbus_pkg::*;
(
    input  trans_t trans_i,
    output ca_t    ca_o
);

    always_comb begin
        ca_o.rw      = ~trans_i.write;
        ca_o.as      = trans_i.reg_space;
        ca_o.burst   = trans_i.linear;
        ca_o.addr_hi = trans_i.addr[31:3];
        ca_o.rsvd    = '0;
        ca_o.addr_lo = trans_i.addr[2:0];
    end

endmodule

// File: rtl/hyperbus_phy_trx.sv
// HyperBus transaction engine: CA phase, initial latency, burst data with
// clock pause on TX stall, read timeout, CS hold and read-write recovery.
module hyperbus_phy_trx
    import hyperbus_pkg::*;
#(
    parameter int NumChips   = 2,
    parameter int BurstWidth = 12,
    parameter int RxTimeout  = 32
) (
    input  logic                        clk_phy_i,
    input  logic                        rst_ni,
    input  logic [3:0]                  cfg_latency_i,
    input  logic [3:0]                  cfg_t_rwr_i,
    input  logic                        cfg_fixed_lat_i,
    input  logic                        trans_valid_i,
    output logic                        trans_ready_o,
    input  logic                        trans_write_i,
    input  logic [31:0]                 trans_addr_i,
    input  logic [BurstWidth-1:0]       trans_burst_i,
    input  logic                        trans_reg_i,
    input  logic                        trans_linear_i,
    input  logic [$clog2(NumChips)-1:0] trans_cs_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic [15:0]                 tx_data_i,
    input  logic [1:0]                  tx_strb_i,
    output logic                        rx_valid_o,
    output logic [15:0]                 rx_data_o,
    output logic                        rx_last_o,
    output logic                        b_valid_o,
    output logic                        err_o,
    output logic [NumChips-1:0]         hyper_cs_no,
    output logic                        hyper_ck_ena_o,
    output logic [15:0]                 hyper_dq_o,
    output logic                        hyper_dq_oe_o,
    output logic [1:0]                  hyper_rwds_o,
    output logic                        hyper_rwds_oe_o,
    input  logic                        hyper_rwds_i,
    input  logic                        rd_valid_i,
    input  logic [15:0]                 rd_data_i
);

    localparam int CsW = $clog2(NumChips);
    localparam int ToW = $clog2(RxTimeout + 1);

    state_e                state_q, state_d;
    trans_t                trans_q, trans_d;
    logic [CsW-1:0]        cs_q, cs_d;
    logic [BurstWidth-1:0] burst_q, burst_d;
    logic [4:0]            phase_q, phase_d;
    logic [ToW-1:0]        to_q, to_d;
    logic                  dbl_q, dbl_d;
    logic                  fixed_q, fixed_d;
    logic [3:0]            lat_q, lat_d;
    logic [3:0]            rwr_q, rwr_d;
    logic [15:0]           dq_q;
    logic [1:0]            rwds_q;
    ca_t                   ca;
    logic [47:0]           ca_bits;
    logic [4:0]            lat_cycles;

    hyperbus_ca_pack u_ca_pack (
        .trans_i (trans_q),
        .ca_o    (ca)
    );

    assign ca_bits    = ca;
    assign lat_cycles = (dbl_q || fixed_q) ? {lat_q, 1'b0} : {1'b0, lat_q};

    always_comb begin
        state_d         = state_q;
        trans_d         = trans_q;
        cs_d            = cs_q;
        burst_d         = burst_q;
        phase_d         = phase_q;
        to_d            = to_q;
        dbl_d           = dbl_q;
        fixed_d         = fixed_q;
        lat_d           = lat_q;
        rwr_d           = rwr_q;
        trans_ready_o   = 1'b0;
        tx_ready_o      = 1'b0;
        rx_valid_o      = 1'b0;
        rx_data_o       = '0;
        rx_last_o       = 1'b0;
        b_valid_o       = 1'b0;
        err_o           = 1'b0;
        hyper_ck_ena_o  = 1'b0;
        hyper_dq_o      = '0;
        hyper_dq_oe_o   = 1'b0;
        hyper_rwds_o    = '0;
        hyper_rwds_oe_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gated with reset so every output reads 0 while rst_ni is low.
                trans_ready_o = rst_ni;
                if (trans_valid_i && rst_ni) begin
                    trans_d.write     = trans_write_i;
                    trans_d.reg_space = trans_reg_i;
                    trans_d.linear    = trans_linear_i;
                    trans_d.addr      = trans_addr_i;
                    cs_d    = trans_cs_i;
                    burst_d = (trans_burst_i == '0) ? BurstWidth'(1) : trans_burst_i;
                    lat_d   = (cfg_latency_i == '0) ? 4'd1 : cfg_latency_i;
                    rwr_d   = (cfg_t_rwr_i == '0) ? 4'd1 : cfg_t_rwr_i;
                    fixed_d = cfg_fixed_lat_i;
                    dbl_d   = 1'b0;
                    phase_d = '0;
                    state_d = CA;
                end
            end
            CA: begin
                hyper_ck_ena_o = 1'b1;
                hyper_dq_oe_o  = 1'b1;
                case (phase_q)
                    5'd0:    hyper_dq_o = ca_bits[47:32];
                    5'd1:    hyper_dq_o = ca_bits[31:16];
                    default: hyper_dq_o = ca_bits[15:0];
                endcase
                if (phase_q == '0) dbl_d = hyper_rwds_i;
                phase_d = phase_q + 5'd1;
                if (phase_q == 5'(CaCycles - 1)) begin
                    if (trans_q.write && trans_q.reg_space) begin
                        state_d = WRITE;
                    end else begin
                        state_d = LAT;
                        phase_d = lat_cycles - 5'd1;
                    end
                end
            end
            LAT: begin
                hyper_ck_ena_o = 1'b1;
                phase_d = phase_q - 5'd1;
                if (phase_q == '0) begin
                    state_d = trans_q.write ? WRITE : READ;
                    to_d    = '0;
                end
            end
            WRITE: begin
                tx_ready_o      = 1'b1;
                hyper_dq_oe_o   = 1'b1;
                hyper_rwds_oe_o = ~trans_q.reg_space;
                // A stall keeps the last driven word on the bus with the clock paused.
                hyper_dq_o      = dq_q;
                hyper_rwds_o    = rwds_q;
                if (tx_valid_i) begin
                    hyper_ck_ena_o = 1'b1;
                    hyper_dq_o     = tx_data_i;
                    hyper_rwds_o   = ~tx_strb_i;
                    burst_d        = burst_q - BurstWidth'(1);
                    if (burst_q == BurstWidth'(1)) state_d = HOLD;
                end
            end
            READ: begin
                hyper_ck_ena_o = 1'b1;
                if (rd_valid_i) begin
                    rx_valid_o = 1'b1;
                    rx_data_o  = rd_data_i;
                    rx_last_o  = (burst_q == BurstWidth'(1));
                    burst_d    = burst_q - BurstWidth'(1);
                    to_d       = '0;
                    if (burst_q == BurstWidth'(1)) state_d = HOLD;
                end else if (to_q == ToW'(RxTimeout - 1)) begin
                    err_o   = 1'b1;
                    state_d = HOLD;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            HOLD: begin
                b_valid_o = trans_q.write;
                phase_d   = {1'b0, rwr_q} - 5'd1;
                state_d   = RWR;
            end
            RWR: begin
                phase_d = phase_q - 5'd1;
                if (phase_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hyper_cs_no = '1;
        if (state_q inside {CA, LAT, WRITE, READ, HOLD}) hyper_cs_no[cs_q] = 1'b0;
    end

    always_ff @(posedge clk_phy_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            trans_q <= '0;
            cs_q    <= '0;
            burst_q <= '0;
            phase_q <= '0;
            to_q    <= '0;
            dbl_q   <= 1'b0;
            fixed_q <= 1'b0;
            lat_q   <= '0;
            rwr_q   <= '0;
            dq_q    <= '0;
            rwds_q  <= '0;
        end else begin
            state_q <= state_d;
            trans_q <= trans_d;
            cs_q    <= cs_d;
            burst_q <= burst_d;
            phase_q <= phase_d;
            to_q    <= to_d;
            dbl_q   <= dbl_d;
            fixed_q <= fixed_d;
            lat_q   <= lat_d;
            rwr_q   <= rwr_d;
            dq_q    <= hyper_dq_o;
            rwds_q  <= hyper_rwds_o;
        end
    end

endmodule

// File: tb/tb_hyperbus_phy_trx.sv
// Directed bench for hyperbus_phy_trx: one task per scenario, inline checks,
// inputs driven at the falling edge and outputs sampled 1 ns later.
module tb_hyperbus_phy_trx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_latency, cfg_t_rwr;
    logic        cfg_fixed;
    logic        trans_valid, trans_ready, trans_write, trans_reg, trans_linear;
    logic [31:0] trans_addr;
    logic [11:0] trans_burst;
    logic [0:0]  trans_cs;
    logic        tx_valid, tx_ready;
    logic [15:0] tx_data;
    logic [1:0]  tx_strb;
    logic        rx_valid, rx_last, b_valid, err;
    logic [15:0] rx_data;
    logic [1:0]  cs_n;
    logic        ck_ena, dq_oe, rwds_oe;
    logic [15:0] dq;
    logic [1:0]  rwds;
    logic        rwds_in, rd_valid;
    logic [15:0] rd_data;

    int errors = 0;
    int checks = 0;

    logic        seen_ready;
    logic [1:0]  seen_cs;
    logic [15:0] seen_ca [3];

    always #5 clk = ~clk;

    hyperbus_phy_trx #(.NumChips(2), .BurstWidth(12), .RxTimeout(32)) dut (
        .clk_phy_i       (clk),
        .rst_ni          (rst_n),
        .cfg_latency_i   (cfg_latency),
        .cfg_t_rwr_i     (cfg_t_rwr),
        .cfg_fixed_lat_i (cfg_fixed),
        .trans_valid_i   (trans_valid),
        .trans_ready_o   (trans_ready),
        .trans_write_i   (trans_write),
        .trans_addr_i    (trans_addr),
        .trans_burst_i   (trans_burst),
        .trans_reg_i     (trans_reg),
        .trans_linear_i  (trans_linear),
        .trans_cs_i      (trans_cs),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready),
        .tx_data_i       (tx_data),
        .tx_strb_i       (tx_strb),
        .rx_valid_o      (rx_valid),
        .rx_data_o       (rx_data),
        .rx_last_o       (rx_last),
        .b_valid_o       (b_valid),
        .err_o           (err),
        .hyper_cs_no     (cs_n),
        .hyper_ck_ena_o  (ck_ena),
        .hyper_dq_o      (dq),
        .hyper_dq_oe_o   (dq_oe),
        .hyper_rwds_o    (rwds),
        .hyper_rwds_oe_o (rwds_oe),
        .hyper_rwds_i    (rwds_in),
        .rd_valid_i      (rd_valid),
        .rd_data_i       (rd_data)
    );

    function automatic logic [15:0] wword(input int k);
        return 16'(16'hC0DE ^ (k * 16'h1111));
    endfunction

    // Presents one descriptor and walks through the three CA cycles, recording what was seen.
    task automatic send_desc(input logic w, input logic r, input logic lin, input logic [31:0] a,
                             input logic [11:0] b, input logic [0:0] c, input logic rw0);
        @(negedge clk);
        trans_valid = 1'b1; trans_write = w; trans_reg = r; trans_linear = lin;
        trans_addr = a; trans_burst = b; trans_cs = c;
        #1 seen_ready = trans_ready;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            trans_valid = 1'b0;
            rwds_in = (i == 0) ? rw0 : 1'b0;
            #1 seen_ca[i] = dq;
            seen_cs = cs_n;
        end
        rwds_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (trans_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1 n++;
        end
        checks++;
        if (trans_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: trans_ready=%b required 1 within 100 cycles", trans_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({cs_n, trans_ready, tx_ready, ck_ena, dq_oe, rwds_oe, b_valid, err, rx_valid} !== 10'b11_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: cs=%b rdy=%b txr=%b ck=%b oe=%b/%b bv=%b err=%b rxv=%b required cs=11 rest 0",
                     cs_n, trans_ready, tx_ready, ck_ena, dq_oe, rwds_oe, b_valid, err, rx_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        #1 checks++;
        if (trans_ready !== 1'b1 || cs_n !== 2'b11) begin
            errors++;
            $display("FAIL reset_idle: trans_ready=%b cs=%b required 1 and 11", trans_ready, cs_n);
        end
    endtask

    task automatic test_mem_write(input string tag, input logic rw0, input logic fixed, input int exp_lat);
        int lat = 0;
        int n = 0;
        int bv = 0;
        logic cs_bad = 1'b0;
        cfg_latency = 4'd6; cfg_fixed = fixed; cfg_t_rwr = 4'd3;
        send_desc(1'b1, 1'b0, 1'b1, 32'h0000_1235, 12'd4, 1'b0, rw0);
        checks++;
        if ({seen_ready, seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]} !== {1'b1, 2'b10, 16'h2000, 16'h0246, 16'h0005}) begin
            errors++;
            $display("FAIL %s_ca: ready=%b cs=%b ca=%h %h %h required 1 10 2000 0246 0005",
                     tag, seen_ready, seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]);
        end
        while (lat < 40) begin
            @(negedge clk);
            tx_valid = 1'b1; tx_data = wword(0); tx_strb = 2'd0;
            #1 if (tx_ready === 1'b1) break;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: lat_cycles=%0d required %0d", tag, lat, exp_lat);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                tx_data = wword(k); tx_strb = 2'(k);
                #1;
            end
            checks++;
            if ({dq, rwds, rwds_oe, dq_oe, ck_ena, tx_ready} !== {wword(k), ~(2'(k)), 4'b1111}) begin
                errors++;
                $display("FAIL %s_word%0d: dq=%h rwds=%b oe=%b/%b ck=%b txr=%b required dq=%h rwds=%b oe=11 ck=1 txr=1",
                         tag, k, dq, rwds, dq_oe, rwds_oe, ck_ena, tx_ready, wword(k), ~(2'(k)));
            end
        end
        @(negedge clk); tx_valid = 1'b0;
        #1 checks++;
        if ({b_valid, cs_n, dq_oe, rwds_oe, ck_ena} !== 6'b1_10_000) begin
            errors++;
            $display("FAIL %s_hold: bv=%b cs=%b oe=%b/%b ck=%b required bv=1 cs=10 oe=00 ck=0",
                     tag, b_valid, cs_n, dq_oe, rwds_oe, ck_ena);
        end
        while (n < 40) begin
            @(negedge clk); #1;
            if (b_valid) bv++;
            if (trans_ready === 1'b1) break;
            if (cs_n !== 2'b11) cs_bad = 1'b1;
            n++;
        end
        checks++;
        if (n != 3 || bv != 0 || cs_bad) begin
            errors++;
            $display("FAIL %s_rwr: cs_high_cycles=%0d extra_bvalid=%0d cs_bad=%b required 3 0 0", tag, n, bv, cs_bad);
        end
    endtask

    task automatic test_reg_write();
        cfg_latency = 4'd6; cfg_fixed = 1'b0; cfg_t_rwr = 4'd1;
        send_desc(1'b1, 1'b1, 1'b1, 32'h0, 12'd1, 1'b1, 1'b0);
        checks++;
        if ({seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]} !== {2'b01, 16'h6000, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reg_ca: cs=%b ca=%h %h %h required 01 6000 0000 0000", seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]);
        end
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 16'h8F1F; tx_strb = 2'b11;
        #1 checks++;
        if ({tx_ready, dq, dq_oe, rwds_oe, ck_ena} !== {1'b1, 16'h8F1F, 3'b101}) begin
            errors++;
            $display("FAIL reg_data: txr=%b dq=%h oe=%b/%b ck=%b required txr=1 dq=8f1f oe=1/0 ck=1",
                     tx_ready, dq, dq_oe, rwds_oe, ck_ena);
        end
        @(negedge clk); tx_valid = 1'b0;
        #1 checks++;
        if (b_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_bvalid: b_valid=%b required 1", b_valid);
        end
        wait_idle();
    endtask

    task automatic test_read();
        int nrx = 0;
        logic lat_rx = 1'b0;
        cfg_latency = 4'd6; cfg_fixed = 1'b0; cfg_t_rwr = 4'd2;
        send_desc(1'b0, 1'b0, 1'b1, 32'h0000_1235, 12'd3, 1'b1, 1'b0);
        checks++;
        if ({seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]} !== {2'b01, 16'hA000, 16'h0246, 16'h0005}) begin
            errors++;
            $display("FAIL read_ca: cs=%b ca=%h %h %h required 01 a000 0246 0005", seen_cs, seen_ca[0], seen_ca[1], seen_ca[2]);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rd_valid = (i == 3); rd_data = 16'hDEAD;
            #1 if (rx_valid !== 1'b0) lat_rx = 1'b1;
        end
        checks++;
        if (lat_rx) begin
            errors++;
            $display("FAIL read_ignore_lat: rx_valid=1 during latency required 0");
        end
        for (int r = 0; r < 8; r++) begin
            logic ev;
            ev = (r == 0 || r == 1 || r == 7);
            @(negedge clk);
            rd_valid = ev; rd_data = 16'(16'h1000 + r);
            #1 checks++;
            if (rx_valid) nrx++;
            if (rx_valid !== ev || rx_last !== (r == 7) || err !== 1'b0 || (ev && rx_data !== 16'(16'h1000 + r))) begin
                errors++;
                $display("FAIL read_cycle%0d: rxv=%b last=%b err=%b data=%h required rxv=%b last=%b err=0 data=%h",
                         r, rx_valid, rx_last, err, rx_data, ev, (r == 7), 16'(16'h1000 + r));
            end
        end
        @(negedge clk); rd_valid = 1'b0;
        #1 checks++;
        if (nrx != 3 || b_valid !== 1'b0 || cs_n !== 2'b01) begin
            errors++;
            $display("FAIL read_hold: words=%0d bv=%b cs=%b required 3 0 01", nrx, b_valid, cs_n);
        end
        wait_idle();
    endtask

    task automatic test_read_timeout();
        int n = 0;
        int errat = -1;
        int lasts = 0;
        cfg_latency = 4'd6; cfg_fixed = 1'b0; cfg_t_rwr = 4'd2;
        send_desc(1'b0, 1'b0, 1'b0, 32'h0000_0040, 12'd2, 1'b0, 1'b0);
        checks++;
        if ({seen_ca[0], seen_ca[1], seen_ca[2]} !== {16'h8000, 16'h0008, 16'h0000}) begin
            errors++;
            $display("FAIL timeout_ca: ca=%h %h %h required 8000 0008 0000", seen_ca[0], seen_ca[1], seen_ca[2]);
        end
        repeat (6) @(negedge clk);
        @(negedge clk);
        rd_valid = 1'b1; rd_data = 16'h5A5A;
        #1 checks++;
        if ({rx_valid, rx_last, rx_data} !== {2'b10, 16'h5A5A}) begin
            errors++;
            $display("FAIL timeout_word: rxv=%b last=%b data=%h required 1 0 5a5a", rx_valid, rx_last, rx_data);
        end
        while (n < 60) begin
            @(negedge clk); rd_valid = 1'b0;
            #1 n++;
            if (rx_last) lasts++;
            if (err === 1'b1) begin errat = n; break; end
        end
        checks++;
        if (errat != 32 || lasts != 0) begin
            errors++;
            $display("FAIL timeout_err: err_after=%0d rx_last_count=%0d required 32 0", errat, lasts);
        end
        @(negedge clk);
        #1 checks++;
        if (err !== 1'b0 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: err=%b bv=%b one cycle after err required 0 0", err, b_valid);
        end
        @(negedge clk);
        #1 checks++;
        if (cs_n !== 2'b11) begin
            errors++;
            $display("FAIL timeout_cs: cs=%b two cycles after err required 11", cs_n);
        end
        wait_idle();
    endtask

    task automatic test_stall_and_reset();
        int lat = 0;
        cfg_latency = 4'd0; cfg_fixed = 1'b0; cfg_t_rwr = 4'd1;
        send_desc(1'b1, 1'b0, 1'b1, 32'h0000_0008, 12'd4, 1'b0, 1'b0);
        while (lat < 40) begin
            @(negedge clk);
            tx_valid = 1'b1; tx_data = wword(0); tx_strb = 2'b11;
            #1 if (tx_ready === 1'b1) break;
            lat++;
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL stall_latency_zero: lat_cycles=%0d required 1", lat);
        end
        @(negedge clk); tx_data = wword(1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); tx_valid = 1'b0; tx_data = 16'hFFFF;
            #1 checks++;
            if ({ck_ena, dq, dq_oe, tx_ready} !== {1'b0, wword(1), 2'b11}) begin
                errors++;
                $display("FAIL stall%0d: ck=%b dq=%h oe=%b txr=%b required ck=0 dq=%h oe=1 txr=1",
                         s, ck_ena, dq, dq_oe, tx_ready, wword(1));
            end
        end
        @(negedge clk); tx_valid = 1'b1; tx_data = wword(2);
        #1 checks++;
        if ({ck_ena, dq} !== {1'b1, wword(2)}) begin
            errors++;
            $display("FAIL stall_resume: ck=%b dq=%h required 1 %h", ck_ena, dq, wword(2));
        end
        @(negedge clk); tx_data = wword(3);
        #1 rst_n = 1'b0;
        #1 checks++;
        if ({cs_n, dq_oe, rwds_oe, ck_ena, b_valid, tx_ready} !== 7'b11_00000) begin
            errors++;
            $display("FAIL async_reset: cs=%b oe=%b/%b ck=%b bv=%b txr=%b required cs=11 rest 0",
                     cs_n, dq_oe, rwds_oe, ck_ena, b_valid, tx_ready);
        end
        tx_valid = 1'b0;
        repeat (2) begin
            @(negedge clk); #1 checks++;
            if (b_valid !== 1'b0 || cs_n !== 2'b11) begin
                errors++;
                $display("FAIL reset_hold: bv=%b cs=%b required 0 11", b_valid, cs_n);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        #1 checks++;
        if (trans_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover: trans_ready=%b required 1", trans_ready);
        end
    endtask

    initial begin
        cfg_latency = 4'd6; cfg_t_rwr = 4'd1; cfg_fixed = 1'b0;
        trans_valid = 1'b0; trans_write = 1'b0; trans_reg = 1'b0; trans_linear = 1'b0;
        trans_addr = '0; trans_burst = '0; trans_cs = '0;
        tx_valid = 1'b0; tx_data = '0; tx_strb = '0;
        rwds_in = 1'b0; rd_valid = 1'b0; rd_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_mem_write("wr_single", 1'b0, 1'b0, 6);
        test_mem_write("wr_rwds_dbl", 1'b1, 1'b0, 12);
        test_mem_write("wr_fixed_dbl", 1'b0, 1'b1, 12);
        test_reg_write();
        test_read();
        test_read_timeout();
        test_stall_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
